microseq_controller: RTL and testbench

Microprogram sequencer for the ARM control unit; sequences the control-store address register and the incrementer register behind the control-unit adder. Each cycle it selects the next microinstruction address from:
- the incremented address
- the microinstruction's CR address field
- the instruction-decoder entry address
- a return-address stack
It also generates the incrementer-register load enable and stalls on memory handshakes (MOC).

---
 rtl/mseq_pkg.sv | 28 ++
 rtl/mseq_ret_stack.sv | 65 ++++++
 rtl/microseq_controller.sv | 147 ++++++++++++++
 tb/tb_microseq_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mseq_pkg.sv
// +-----------------------------------------------------------------------+
// | Module : mseq_pkg                                                     |
// | Shared NS encodings, FSM states and defaults for microseq_controller. |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

package mseq_pkg;

   localparam int ADDR_W_DEF = 8;

   localparam logic [2:0] NS_DECODE = 3'd0;
   localparam logic [2:0] NS_FETCH  = 3'd1;
   localparam logic [2:0] NS_INC    = 3'd2;
   localparam logic [2:0] NS_JUMP   = 3'd3;
   localparam logic [2:0] NS_CJUMP  = 3'd4;
   localparam logic [2:0] NS_CALL   = 3'd5;
   localparam logic [2:0] NS_RET    = 3'd6;
   localparam logic [2:0] NS_WAIT   = 3'd7;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } mseq_state_e;

endpackage

`default_nettype wire

// File: rtl/mseq_ret_stack.sv
// +-----------------------------------------------------------------------+
// | Module : mseq_ret_stack                                               |
// | LIFO return-address stack; pushes when full are dropped.              |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module mseq_ret_stack
   import mseq_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int CNT_W = $clog2(STACK_DEPTH + 1);
   localparam int PTR_W = $clog2(STACK_DEPTH);

   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  top_ptr;
   logic [ADDR_W-1:0] mem_q [STACK_DEPTH];

   assign full    = (count_q == CNT_W'(STACK_DEPTH));
   assign empty   = (count_q == '0);
   // With count==DEPTH the low bits wrap to 0, so top_ptr lands on DEPTH-1.
   assign wr_ptr  = count_q[PTR_W-1:0];
   assign top_ptr = count_q[PTR_W-1:0] - PTR_W'(1);
   assign dout    = mem_q[top_ptr];

   always_comb begin
      count_d = count_q;
      if (push && !full) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !empty) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_q[wr_ptr] <= din;
      end
   end

endmodule

`default_nettype wire

// File: rtl/microseq_controller.sv
// +-----------------------------------------------------------------------+
// | Module : microseq_controller                                          |
// | Microprogram sequencer; optional return stack via MSEQ_RET_STACK_EN.  |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module microseq_controller
   import mseq_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int STACK_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [2:0]        NS,
   input  logic [ADDR_W-1:0] CR_ADDR,
   input  logic [ADDR_W-1:0] DEC_ADDR,
   input  logic              COND,
   input  logic              INV,
   input  logic              MOC,
   output logic [ADDR_W-1:0] ADDR_OUT,
   output logic              INC_EN,
   output logic [ADDR_W-1:0] INC_Q,
   output logic              STALL,
   output logic              ERR
);

   mseq_state_e       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] inc_q, inc_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] next_addr;
   logic              advance;

   if (STACK_DEPTH < 2 || STACK_DEPTH > 16 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("STACK_DEPTH must be a power of two in 2..16");
   end

`ifdef MSEQ_RET_STACK_EN
   logic              push, pop;
   logic              stk_full, stk_empty;
   logic [ADDR_W-1:0] stk_dout;

   mseq_ret_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .clk   (CLK),
      .rst_n (RESET),
      .push  (push),
      .pop   (pop),
      .din   (inc_q),
      .dout  (stk_dout),
      .full  (stk_full),
      .empty (stk_empty)
   );
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      inc_d     = inc_q;
      err_d     = err_q;
      next_addr = inc_q;
      advance   = 1'b0;
`ifdef MSEQ_RET_STACK_EN
      push      = 1'b0;
      pop       = 1'b0;
`endif
      case (state_q)
         ST_STALL: begin
            // NS is ignored here: the held microinstruction is the WAIT.
            if (MOC) begin
               advance = 1'b1;
               state_d = ST_RUN;
            end
         end
         default: begin
            advance = 1'b1;
            case (NS)
               NS_DECODE: next_addr = DEC_ADDR;
               NS_FETCH:  next_addr = '0;
               NS_INC:    next_addr = inc_q;
               NS_JUMP:   next_addr = CR_ADDR;
               NS_CJUMP: begin
                  if (COND ^ INV) next_addr = CR_ADDR;
               end
               NS_CALL: begin
                  next_addr = CR_ADDR;
`ifdef MSEQ_RET_STACK_EN
                  push = 1'b1;
                  if (stk_full) err_d = 1'b1;
`endif
               end
               NS_RET: begin
`ifdef MSEQ_RET_STACK_EN
                  if (stk_empty) begin
                     next_addr = '0;
                     err_d     = 1'b1;
                  end else begin
                     pop       = 1'b1;
                     next_addr = stk_dout;
                  end
`else
                  next_addr = '0;
`endif
               end
               NS_WAIT: begin
                  if (!MOC) begin
                     advance = 1'b0;
                     state_d = ST_STALL;
                  end
               end
               default: next_addr = inc_q;
            endcase
         end
      endcase
      if (advance) begin
         addr_d = next_addr;
         inc_d  = next_addr + ADDR_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_RUN;
         addr_q  <= '0;
         inc_q   <= ADDR_W'(1);
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         inc_q   <= inc_d;
         err_q   <= err_d;
      end
   end

   assign ADDR_OUT = addr_q;
   assign INC_Q    = inc_q;
   assign INC_EN   = advance;
   assign STALL    = (state_q == ST_STALL);
   assign ERR      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_microseq_controller.sv
// +-----------------------------------------------------------------------+
// | Module : tb_microseq_controller                                       |
// | Directed bench for microseq_controller (honours MSEQ_RET_STACK_EN).   |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_microseq_controller;

`ifdef MSEQ_RET_STACK_EN
   localparam bit HAS_STACK = 1'b1;
`else
   localparam bit HAS_STACK = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic [2:0] NS = 3'd2;
   logic [7:0] CR_ADDR = 8'h00;
   logic [7:0] DEC_ADDR = 8'h00;
   logic       COND = 1'b0;
   logic       INV = 1'b0;
   logic       MOC = 1'b0;
   logic [7:0] ADDR_OUT;
   logic       INC_EN;
   logic [7:0] INC_Q;
   logic       STALL;
   logic       ERR;

   int checks = 0;
   int failures = 0;

   microseq_controller #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .NS       (NS),
      .CR_ADDR  (CR_ADDR),
      .DEC_ADDR (DEC_ADDR),
      .COND     (COND),
      .INV      (INV),
      .MOC      (MOC),
      .ADDR_OUT (ADDR_OUT),
      .INC_EN   (INC_EN),
      .INC_Q    (INC_Q),
      .STALL    (STALL),
      .ERR      (ERR)
   );

   always #5 CLK = ~CLK;

   // Inputs change 1 time unit after a rising edge; checks follow at +1.
   task automatic drive(input logic [2:0] ns, input logic [7:0] cr,
                        input logic cond, input logic inv, input logic moc);
      NS = ns; CR_ADDR = cr; COND = cond; INV = inv; MOC = moc;
      #1;
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset;
      #2 RESET = 1'b0;
      #3 RESET = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      RESET = 1'b0;
      drive(3'd2, 8'h00, 0, 0, 0);
      tick(); tick();
      checks++; if (ADDR_OUT !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", ADDR_OUT); end
      checks++; if (INC_Q !== 8'h01) begin failures++; $display("FAIL reset_inc got=%h exp=01", INC_Q); end
      checks++; if (STALL !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL reset_flags stall=%b err=%b exp=0/0", STALL, ERR); end
      RESET = 1'b1;
      #1;
   endtask

   task automatic test_increment;
      for (int i = 1; i <= 3; i++) begin
         drive(3'd2, 8'h00, 0, 0, 0);
         checks++; if (INC_EN !== 1'b1) begin failures++; $display("FAIL inc_en[%0d] got=%b exp=1", i, INC_EN); end
         tick();
         checks++; if (ADDR_OUT !== 8'(i) || INC_Q !== 8'(i + 1)) begin failures++; $display("FAIL inc_seq[%0d] addr=%h inc=%h exp=%h/%h", i, ADDR_OUT, INC_Q, 8'(i), 8'(i + 1)); end
      end
      drive(3'd0, 8'h00, 0, 0, 0);
      DEC_ADDR = 8'h5A;
      tick();
      checks++; if (ADDR_OUT !== 8'h5A) begin failures++; $display("FAIL decode got=%h exp=5a", ADDR_OUT); end
      drive(3'd1, 8'h00, 0, 0, 0);
      tick();
      checks++; if (ADDR_OUT !== 8'h00 || INC_Q !== 8'h01) begin failures++; $display("FAIL fetch addr=%h inc=%h exp=00/01", ADDR_OUT, INC_Q); end
   endtask

   task automatic test_wait_stall;
      drive(3'd3, 8'h10, 0, 0, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(3'd7, 8'h00, 0, 0, 0);
         checks++; if (INC_EN !== 1'b0) begin failures++; $display("FAIL stall_inc_en[%0d] got=%b exp=0", i, INC_EN); end
         tick();
         checks++; if (ADDR_OUT !== 8'h10 || INC_Q !== 8'h11 || STALL !== 1'b1) begin failures++; $display("FAIL stall_hold[%0d] addr=%h inc=%h stall=%b exp=10/11/1", i, ADDR_OUT, INC_Q, STALL); end
      end
      // NS is deliberately not WAIT here; STALL must ignore it.
      drive(3'd3, 8'hEE, 0, 0, 1);
      checks++; if (INC_EN !== 1'b1) begin failures++; $display("FAIL stall_release_en got=%b exp=1", INC_EN); end
      tick();
      checks++; if (ADDR_OUT !== 8'h11 || STALL !== 1'b0) begin failures++; $display("FAIL stall_release addr=%h stall=%b exp=11/0", ADDR_OUT, STALL); end
      drive(3'd7, 8'h00, 0, 0, 1);
      tick();
      checks++; if (ADDR_OUT !== 8'h12 || STALL !== 1'b0) begin failures++; $display("FAIL wait_moc_now addr=%h stall=%b exp=12/0", ADDR_OUT, STALL); end
   endtask

   task automatic test_cjump;
      drive(3'd3, 8'h08, 0, 0, 0); tick();
      drive(3'd4, 8'h40, 1, 0, 0); tick();
      checks++; if (ADDR_OUT !== 8'h40) begin failures++; $display("FAIL cjump_taken got=%h exp=40", ADDR_OUT); end
      drive(3'd3, 8'h08, 0, 0, 0); tick();
      drive(3'd4, 8'h40, 1, 1, 0); tick();
      checks++; if (ADDR_OUT !== 8'h09) begin failures++; $display("FAIL cjump_inv got=%h exp=09", ADDR_OUT); end
      drive(3'd4, 8'h40, 0, 1, 0); tick();
      checks++; if (ADDR_OUT !== 8'h40) begin failures++; $display("FAIL cjump_inv_taken got=%h exp=40", ADDR_OUT); end
   endtask

   task automatic test_call_ret;
      logic [7:0] ret_exp [4];
      logic [7:0] tgt [4];
      ret_exp = '{8'h71, 8'h61, 8'h51, 8'h31};
      tgt     = '{8'h50, 8'h60, 8'h70, 8'h90};
      do_reset();
      drive(3'd3, 8'h20, 0, 0, 0); tick();
      drive(3'd5, 8'h80, 0, 0, 0); tick();
      checks++; if (ADDR_OUT !== 8'h80) begin failures++; $display("FAIL call_target got=%h exp=80", ADDR_OUT); end
      drive(3'd2, 8'h00, 0, 0, 0); tick();
      drive(3'd2, 8'h00, 0, 0, 0); tick();
      checks++; if (ADDR_OUT !== 8'h82) begin failures++; $display("FAIL call_body got=%h exp=82", ADDR_OUT); end
      drive(3'd6, 8'h00, 0, 0, 0); tick();
      checks++; if (ADDR_OUT !== (HAS_STACK ? 8'h21 : 8'h00)) begin failures++; $display("FAIL ret_addr got=%h exp=%h", ADDR_OUT, HAS_STACK ? 8'h21 : 8'h00); end
      drive(3'd3, 8'h30, 0, 0, 0); tick();
      for (int i = 0; i < 4; i++) begin
         drive(3'd5, tgt[i], 0, 0, 0); tick();
      end
      for (int i = 0; i < 4; i++) begin
         drive(3'd6, 8'h00, 0, 0, 0); tick();
         checks++; if (ADDR_OUT !== (HAS_STACK ? ret_exp[i] : 8'h00)) begin failures++; $display("FAIL nested_ret[%0d] got=%h exp=%h", i, ADDR_OUT, HAS_STACK ? ret_exp[i] : 8'h00); end
      end
      checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL nested_err got=%b exp=0", ERR); end
   endtask

   task automatic test_overflow_underflow;
      logic [7:0] tgt [5];
      tgt = '{8'h50, 8'h60, 8'h70, 8'h90, 8'hA0};
      do_reset();
      drive(3'd3, 8'h30, 0, 0, 0); tick();
      for (int i = 0; i < 5; i++) begin
         drive(3'd5, tgt[i], 0, 0, 0); tick();
         if (i == 3) begin
            checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL full_no_err got=%b exp=0", ERR); end
         end
      end
      checks++; if (ADDR_OUT !== 8'hA0) begin failures++; $display("FAIL overflow_target got=%h exp=a0", ADDR_OUT); end
      checks++; if (ERR !== HAS_STACK) begin failures++; $display("FAIL overflow_err got=%b exp=%b", ERR, HAS_STACK); end
      drive(3'd6, 8'h00, 0, 0, 0); tick();
      checks++; if (ADDR_OUT !== (HAS_STACK ? 8'h71 : 8'h00)) begin failures++; $display("FAIL overflow_ret got=%h exp=%h", ADDR_OUT, HAS_STACK ? 8'h71 : 8'h00); end
      for (int i = 0; i < 3; i++) begin
         drive(3'd6, 8'h00, 0, 0, 0); tick();
      end
      drive(3'd2, 8'h00, 0, 0, 0); tick();
      drive(3'd6, 8'h00, 0, 0, 0); tick();
      checks++; if (ADDR_OUT !== 8'h00 || INC_Q !== 8'h01) begin failures++; $display("FAIL underflow_addr addr=%h inc=%h exp=00/01", ADDR_OUT, INC_Q); end
      drive(3'd2, 8'h00, 0, 0, 0); tick(); tick();
      checks++; if (ERR !== HAS_STACK) begin failures++; $display("FAIL err_sticky got=%b exp=%b", ERR, HAS_STACK); end
   endtask

   task automatic test_wrap_async_reset;
      drive(3'd3, 8'hFF, 0, 0, 0); tick();
      checks++; if (INC_Q !== 8'h00) begin failures++; $display("FAIL wrap_inc_ff got=%h exp=00", INC_Q); end
      drive(3'd2, 8'h00, 0, 0, 0); tick();
      checks++; if (ADDR_OUT !== 8'h00 || INC_Q !== 8'h01) begin failures++; $display("FAIL wrap addr=%h inc=%h exp=00/01", ADDR_OUT, INC_Q); end
      drive(3'd6, 8'h00, 0, 0, 0); tick();
      drive(3'd3, 8'h10, 0, 0, 0); tick();
      drive(3'd7, 8'h00, 0, 0, 0); tick(); tick();
      checks++; if (STALL !== 1'b1 || ERR !== HAS_STACK) begin failures++; $display("FAIL pre_reset stall=%b err=%b exp=1/%b", STALL, ERR, HAS_STACK); end
      #1 RESET = 1'b0;
      #1;
      checks++; if (ADDR_OUT !== 8'h00 || INC_Q !== 8'h01 || STALL !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL async_reset addr=%h inc=%h stall=%b err=%b exp=00/01/0/0", ADDR_OUT, INC_Q, STALL, ERR); end
      #1 RESET = 1'b1;
      drive(3'd2, 8'h00, 0, 0, 0); tick();
      checks++; if (ADDR_OUT !== 8'h01 || STALL !== 1'b0) begin failures++; $display("FAIL post_reset addr=%h stall=%b exp=01/0", ADDR_OUT, STALL); end
   endtask

   initial begin
      test_reset();
      test_increment();
      test_wait_stall();
      test_cjump();
      test_call_ret();
      test_overflow_underflow();
      test_wrap_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
